vilk_out_capture: RTL and testbench
===================================

// Module: vilk_out_capture
// PURPOSE
//  Downstream stage of the DietVilk core. Watches the core's 16-bit outputValue bus
//  and captures each new value into a small FIFO. Presents the captured values to a
//  consumer (host/UART/bench monitor) over a valid/ready handshake, so no output
//  written by a running program is lost while the consumer is stalled.
// PARAMETERS
//  DATA_W  16  width of outputValue and of each FIFO entry
//  DEPTH   8   FIFO entries; must be a power of two
//  PTR_W   3   log2(DEPTH); read/write pointer width
// PORTS
//  CLK          in   1        system clock; all state updates on posedge
//  reset        in   1        synchronous, active-high reset
//  outputValue  in   DATA_W   DietVilk output port value
//  out_data     out  DATA_W   head-of-FIFO value; 0 when empty
//  out_valid    out  1        FIFO non-empty
//  out_ready    in   1        consumer accepts out_data this cycle
//  count        out  PTR_W+1  number of stored entries, 0..DEPTH
//  overflow     out  1        sticky: a capture was dropped because FIFO was full
// BEHAVIOUR
//  Reset (reset=1 at posedge): wr_ptr=rd_ptr=0, count=0, last_q=0, overflow=0;
//   outputs out_valid=0, out_data=0, count=0 the cycle after. Storage contents don't-care.
//   Reset mid-operation flushes all entries; nothing from before reset is delivered.
//  Change detect: push = (outputValue != last_q). On each non-reset posedge
//   last_q <= outputValue. Consequences: value 0 after reset is never captured; a value
//   held for N cycles is captured once; A->B->A captures three entries.
//  Pop: pop = out_valid & out_ready. out_ready while empty is ignored.
//  Write: push & (~full | pop) -> mem[wr_ptr] <= outputValue, wr_ptr += 1 (mod DEPTH).
//  Drop: push & full & ~pop -> entry discarded, overflow <= 1 (stays 1 until reset).
//  Read: pop -> rd_ptr += 1 (mod DEPTH). Pointers wrap silently at DEPTH-1 -> 0.
//  Count: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
//  Latency: value changes at edge k (sampled at posedge k+1) -> out_valid/out_data
//   reflect it after posedge k+1 when FIFO was empty. No same-cycle bypass.
//  out_data: first-word-fall-through, combinational from mem[rd_ptr] gated by out_valid.
//   out_data/out_valid must not change while out_valid=1 and out_ready=0, except by reset.
//  Simultaneous push+pop when full: both accepted, count stays DEPTH, no overflow.
//  Simultaneous push+pop when empty: pop is void (out_valid=0); push accepted, count=1.
//  full = (count == DEPTH); empty = (count == 0); derived from count, not pointers.
// STRUCTURE
//  Shared package vilk_io_pkg: VILK_DATA_W=16, VILK_OUT_DEPTH=8, VILK_OUT_PTR_W=3;
//   the DietVilk core and this block both take DATA_W from it.
//  One sub-module: vilk_sync_fifo (DATA_W, DEPTH, PTR_W; push/pop/full/empty/count,
//   FWFT head). Top level holds last_q, change detect, drop/overflow logic.
//  Target ~150-250 lines RTL total.
// TESTING
//  1 reset 2 cycles, outputValue=0 held 20 cycles -> out_valid=0, count=0, overflow=0.
//  2 out_ready=1, outputValue 0->16'h13b0 -> one cycle later out_valid=1,
//    out_data=16'h13b0; popped that cycle; count back to 0; no second entry while held.
//  3 out_ready=0, outputValue 1,2,...,9 one per cycle -> count=8, overflow=1;
//    then out_ready=1 -> drains 1..8 in order, value 9 never appears, overflow stays 1.
//  4 FIFO full, out_ready=1, outputValue changes to 16'hBEEF same cycle -> count stays 8,
//    overflow stays 0; 16'hBEEF delivered as the 8th entry after the current head.
//  5 wrap: 20 distinct values with out_ready toggling 1/0 each cycle -> all delivered
//    in order, none duplicated or lost, count never exceeds 8.
//  6 count=5, assert reset one cycle while outputValue=16'h0042 held -> count=0,
//    out_valid=0, overflow=0; after release 16'h0042 is captured once (differs from last_q=0).

Source files
------------

// File: rtl/vilk_io_pkg.sv
// Shared I/O parameters for the DietVilk core and its output capture stage.
package vilk_io_pkg;

    localparam int VILK_DATA_W    = 16;
    localparam int VILK_OUT_DEPTH = 8;
    localparam int VILK_OUT_PTR_W = 3;

endpackage : vilk_io_pkg

// File: rtl/vilk_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an occupancy counter.
// Full/empty come from the counter so pointer equality is never ambiguous.
module vilk_sync_fifo
    import vilk_io_pkg::*;
#(
    parameter int DATA_W = VILK_DATA_W,
    parameter int DEPTH  = VILK_OUT_DEPTH,
    parameter int PTR_W  = VILK_OUT_PTR_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop on an empty FIFO is void; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head is read combinationally and forced to zero when nothing is stored.
    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage write; contents are don't-care after reset so no reset here.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : vilk_sync_fifo

// File: rtl/vilk_out_capture.sv
// Captures every change on the core's outputValue bus into a FIFO and offers
// the captured values to a consumer over valid/ready. Drops are flagged stickily.
module vilk_out_capture
    import vilk_io_pkg::*;
#(
    parameter int DATA_W = VILK_DATA_W,
    parameter int DEPTH  = VILK_OUT_DEPTH,
    parameter int PTR_W  = VILK_OUT_PTR_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] outputValue,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W:0]    count,
    output logic              overflow
);

    logic [DATA_W-1:0] last_q_reg;
    logic              overflow_reg;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;

    // A capture happens whenever the bus differs from the previous cycle's value.
    // last_q resets to zero, so a zero held out of reset is never captured.
    assign push = (outputValue != last_q_reg);
    assign pop  = out_valid & out_ready;
    assign drop = push & fifo_full & ~pop;

    assign out_valid = ~fifo_empty;
    assign overflow  = overflow_reg;

    vilk_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (outputValue),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Track the previously seen bus value for change detection.
    always_ff @(posedge CLK) begin
        if (reset) begin
            last_q_reg <= '0;
        end else begin
            last_q_reg <= outputValue;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule : vilk_out_capture

// File: tb/tb_vilk_out_capture.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based model of the capture stage.
module tb_vilk_out_capture;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic              CLK;
    logic              reset;
    logic [DATA_W-1:0] outputValue;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [PTR_W:0]    count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] mlast = '0;
    logic              movf  = 1'b0;

    vilk_out_capture dut (
        .CLK         (CLK),
        .reset       (reset),
        .outputValue (outputValue),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model at the edge, compare on the falling edge.
    task automatic cycle(input logic r, input logic [DATA_W-1:0] v, input logic rdy);
        bit full;
        bit do_pop;
        reset       = r;
        outputValue = v;
        out_ready   = rdy;
        @(posedge CLK);
        if (r) begin
            mq.delete();
            mlast = '0;
            movf  = 1'b0;
        end else begin
            full   = (mq.size() == DEPTH);
            do_pop = (mq.size() > 0) && rdy;
            if (do_pop) begin
                $display("pop  data=%h", mq[0]);
                void'(mq.pop_front());
            end
            if (v != mlast) begin
                if (!full || do_pop) begin
                    mq.push_back(v);
                    $display("push data=%h", v);
                end else begin
                    movf = 1'b1;
                    $display("drop data=%h", v);
                end
            end
            mlast = v;
        end
        @(negedge CLK);
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("out_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("overflow", 32'(overflow), 32'(movf));
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] pool [4];
        reset       = 1'b1;
        outputValue = '0;
        out_ready   = 1'b0;
        @(negedge CLK);

        // 1: reset, then zero held
        cycle(1'b1, 16'h0, 1'b0);
        cycle(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 1'b0);
        check_eq("s1_valid", 32'(out_valid), 32'h0);
        check_eq("s1_count", 32'(count), 32'h0);
        check_eq("s1_ovf", 32'(overflow), 32'h0);

        // 2: single capture, popped next cycle, no repeat while held
        cycle(1'b0, 16'h13b0, 1'b1);
        check_eq("s2_valid", 32'(out_valid), 32'h1);
        check_eq("s2_data", 32'(out_data), 32'h13b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h13b0, 1'b1);
        check_eq("s2_count", 32'(count), 32'h0);

        // 3: overfill with consumer stalled, then drain
        for (int i = 1; i <= 9; i++) cycle(1'b0, 16'(i), 1'b0);
        check_eq("s3_count", 32'(count), 32'h8);
        check_eq("s3_ovf", 32'(overflow), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            check_eq("s3_drain", 32'(out_data), 32'(i));
            cycle(1'b0, 16'h9, 1'b1);
        end
        check_eq("s3_empty", 32'(out_valid), 32'h0);
        check_eq("s3_ovf_sticky", 32'(overflow), 32'h1);

        // 4: push and pop together while full
        cycle(1'b1, 16'h0, 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b0, 16'h100 + 16'(i), 1'b0);
        cycle(1'b0, 16'hBEEF, 1'b1);
        check_eq("s4_count", 32'(count), 32'h8);
        check_eq("s4_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 16'hBEEF, 1'b1);
        check_eq("s4_last", 32'(out_data), 32'hBEEF);
        cycle(1'b0, 16'hBEEF, 1'b1);
        check_eq("s4_drained", 32'(count), 32'h0);

        // 5: wrap with toggling ready
        v = 16'hBEEF;
        for (int i = 0; i < 20; i++) begin
            v = v ^ (16'($urandom_range(1, 16'hFFFF)));
            cycle(1'b0, v, 1'(i % 2));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, v, 1'b1);
        check_eq("s5_drained", 32'(count), 32'h0);

        // 6: reset flushes, held value captured once afterwards
        for (int i = 1; i <= 5; i++) cycle(1'b0, 16'h200 + 16'(i), 1'b0);
        check_eq("s6_count5", 32'(count), 32'h5);
        cycle(1'b1, 16'h0042, 1'b0);
        check_eq("s6_rst_count", 32'(count), 32'h0);
        check_eq("s6_rst_valid", 32'(out_valid), 32'h0);
        cycle(1'b0, 16'h0042, 1'b0);
        cycle(1'b0, 16'h0042, 1'b0);
        check_eq("s6_once", 32'(count), 32'h1);
        check_eq("s6_data", 32'(out_data), 32'h0042);

        // Random traffic over a small value pool so A->B->A patterns recur
        for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) v = pool[$urandom_range(0, 3)];
            cycle(($urandom_range(0, 63) == 0), v, 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vilk_out_capture
